// File: rtl/watch_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: FSM states,
// segment bit positions inside a digit byte, and a width helper.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Bit positions inside one digit byte {a,b,c,d,e,f,g,dp}
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bus bundle between a controller and the segment scanner: load/enable
// controls in one direction, multiplexed drive outputs in the other.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    en;
  logic                    load;
  logic [8*NUM_DIGITS-1:0] seg_data;
  logic [7:0]              seg_out;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_done;

  modport master (
    output en, load, seg_data,
    input  seg_out, digit_sel, frame_done
  );

  modport slave (
    input  en, load, seg_data,
    output seg_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner: each digit slot starts with a short
// all-off gap, then lights one digit; new data is swapped in only at frame start.
module seg_scan
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CNT_W = idx_width(PRESCALE);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [8*NUM_DIGITS-1:0] r_pending;
  logic [8*NUM_DIGITS-1:0] r_shadow;

  scan_state_t             w_state_next;
  logic [IDX_W-1:0]        w_idx_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_pending <= '0;
      r_shadow  <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      // Shadow samples pending before this edge's load lands in pending
      if (w_xfer) r_shadow  <= r_pending;
      if (load)   r_pending <= seg_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_xfer       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_next = ST_BLANK;
          w_idx_next   = '0;
          w_cnt_next   = '0;
          w_xfer       = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!en) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == CNT_BLANK_LAST) w_state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_SLOT_LAST) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_next = '0;
            w_xfer     = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so select and data move together
  logic [NUM_DIGITS-1:0] w_lit;
  logic [7:0]            w_masked [NUM_DIGITS];
  logic [7:0]            w_seg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_lit[gi]    = (r_state == ST_SHOW) && (r_idx == IDX_W'(gi));
    assign w_masked[gi] = r_shadow[8*gi +: 8] & {8{w_lit[gi]}};
  end

  always_comb begin
    w_seg = '0;
    for (int k = 0; k < NUM_DIGITS; k++) w_seg = w_seg | w_masked[k];
  end

  assign seg_out    = w_seg;
  assign digit_sel  = w_lit;
  assign frame_done = (r_state == ST_SHOW) && (r_idx == IDX_LAST) &&
                      (r_cnt == CNT_SLOT_LAST);

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a time-based reference model checked every cycle, a
// first-frame vector table, hand sequences for corner cases, then random traffic.
module tb_seg_scan;
  localparam int ND    = 4;
  localparam int PRE   = 8;
  localparam int BLK   = 2;
  localparam int FRAME = ND * PRE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan #(.NUM_DIGITS(ND), .PRESCALE(PRE), .BLANK_CYCLES(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .load       (bus.load),
    .seg_data   (bus.seg_data),
    .seg_out    (bus.seg_out),
    .digit_sel  (bus.digit_sel),
    .frame_done (bus.frame_done)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: cycles elapsed since scanning began, plus frame contents
  bit              m_active = 1'b0;
  int              m_t      = 0;
  logic [8*ND-1:0] m_pending = '0;
  logic [8*ND-1:0] m_frame   = '0;

  task automatic model_edge();
    if (rst) begin
      m_active  = 1'b0;
      m_t       = 0;
      m_pending = '0;
      m_frame   = '0;
    end else begin
      if (!m_active) begin
        if (bus.en) begin
          m_active = 1'b1;
          m_t      = 0;
          m_frame  = m_pending;
        end
      end else if (!bus.en) begin
        m_active = 1'b0;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) m_frame = m_pending;
      end
      if (bus.load) m_pending = bus.seg_data;
    end
  endtask

  task automatic model_check();
    int p, slot, off;
    logic [7:0]    e_seg;
    logic [ND-1:0] e_sel;
    logic          e_fd;
    e_seg = '0; e_sel = '0; e_fd = 1'b0;
    if (m_active) begin
      p    = m_t % FRAME;
      slot = p / PRE;
      off  = p % PRE;
      if (off >= BLK) begin
        e_sel = ND'(1) << slot;
        e_seg = m_frame[8*slot +: 8];
      end
      e_fd = (p == FRAME - 1);
    end
    chk("model_seg_out", int'(bus.seg_out), int'(e_seg));
    chk("model_digit_sel", int'(bus.digit_sel), int'(e_sel));
    chk("model_frame_done", int'(bus.frame_done), int'(e_fd));
    chk("onehot_sel", int'($countones(bus.digit_sel) <= 1), 1);
    chk("dark_when_unselected", int'(bus.digit_sel == '0 && bus.seg_out != '0), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_out(input string name, input int seg, input int sel, input int fd);
    chk({name, "_seg"}, int'(bus.seg_out), seg);
    chk({name, "_sel"}, int'(bus.digit_sel), sel);
    chk({name, "_fd"}, int'(bus.frame_done), fd);
  endtask

  typedef struct {
    int         cyc;
    logic [7:0] seg;
    logic [3:0] sel;
    logic       fd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int ti;
    vecs[0]  = '{0,  8'h00, 4'h0, 1'b0};
    vecs[1]  = '{1,  8'h00, 4'h0, 1'b0};
    vecs[2]  = '{2,  8'h79, 4'h1, 1'b0};
    vecs[3]  = '{7,  8'h79, 4'h1, 1'b0};
    vecs[4]  = '{8,  8'h00, 4'h0, 1'b0};
    vecs[5]  = '{10, 8'h6D, 4'h2, 1'b0};
    vecs[6]  = '{18, 8'h30, 4'h4, 1'b0};
    vecs[7]  = '{26, 8'h7E, 4'h8, 1'b0};
    vecs[8]  = '{30, 8'h7E, 4'h8, 1'b0};
    vecs[9]  = '{31, 8'h7E, 4'h8, 1'b1};
    vecs[10] = '{32, 8'h00, 4'h0, 1'b0};

    bus.en = 1'b0; bus.load = 1'b0; bus.seg_data = '0;

    // Reset state
    run(2);
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;

    // First frame against the vector table
    bus.load = 1'b1; bus.seg_data = 32'h7E30_6D79;
    run(1);
    bus.load = 1'b0; bus.en = 1'b1;
    ti = 0;
    for (int k = 0; k <= 32; k++) begin
      tick();
      if (ti < 11 && vecs[ti].cyc == k) begin
        chk($sformatf("vec%0d_seg", k), int'(bus.seg_out), int'(vecs[ti].seg));
        chk($sformatf("vec%0d_sel", k), int'(bus.digit_sel), int'(vecs[ti].sel));
        chk($sformatf("vec%0d_fd", k), int'(bus.frame_done), int'(vecs[ti].fd));
        ti++;
      end
    end

    // Mid-frame load: current frame keeps old bytes, next frame is all 0x5B
    bus.load = 1'b1; bus.seg_data = 32'h5B5B_5B5B;
    run(1);
    bus.load = 1'b0;
    run(26);
    chk_out("midload_old", 'h7E, 'h8, 0);
    run(12);
    chk_out("midload_new0", 'h5B, 'h1, 0);
    run(8);
    chk_out("midload_new1", 'h5B, 'h2, 0);

    // Load on the wrap edge: one more frame of the previous pending value
    run(16);
    chk_out("wrap_last", 'h5B, 'h8, 1);
    bus.load = 1'b1; bus.seg_data = 32'h1122_3344;
    run(1);
    bus.load = 1'b0;
    run(6);
    chk_out("wrap_prev", 'h5B, 'h1, 0);
    run(32);
    chk_out("wrap_new", 'h44, 'h1, 0);

    // Drop enable during digit 2, then resume from digit 0
    run(14);
    chk_out("pre_drop", 'h22, 'h4, 0);
    bus.en = 1'b0;
    run(1);
    chk_out("drop", 0, 0, 0);
    run(3);
    bus.en = 1'b1;
    run(2);
    chk_out("resume_blank", 0, 0, 0);
    run(1);
    chk_out("resume_show", 'h44, 'h1, 0);

    // Reset mid-SHOW clears pending; restart shows blank bytes on a lit digit
    rst = 1'b1;
    run(1);
    chk_out("rst_mid", 0, 0, 0);
    rst = 1'b0; bus.en = 1'b0;
    run(1);
    bus.en = 1'b1;
    run(3);
    chk_out("after_rst", 0, 'h1, 0);

    // Random load/enable traffic against the model
    for (int i = 0; i < 1000; i++) begin
      bus.en       = ($urandom_range(0, 15) != 0);
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.seg_data = $urandom;
      rst          = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
